// File: rtl/op_lut_pkg.sv
// Shared definitions for the output-port-lookup preprocess path: IPv4 header
// offsets within a 256-bit beat, parser states, result entry and 16-bit one's-complement add.
package op_lut_pkg;

    localparam int unsigned IP_VER_IHL_HI = 143;
    localparam int unsigned IP_TTL_HI     = 79;
    localparam int unsigned IP_PROTO_HI   = 71;
    localparam int unsigned IP_CKSUM_HI   = 63;
    localparam int unsigned IP_HDR1_HI    = 143;
    localparam int unsigned IP_HDR1_WORDS = 9;
    localparam int unsigned IP_HDR2_HI    = 255;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;

    typedef enum logic [1:0] {
        StWord1   = 2'd0,
        StWord2   = 2'd1,
        StWaitEop = 2'd2
    } parse_state_e;

    typedef struct packed {
        logic       is_good;
        logic       has_options;
        logic       ttl_good;
        logic [7:0] new_ttl;
        logic [15:0] new_cksum;
    } info_entry_t;

    localparam int unsigned INFO_WIDTH = $bits(info_entry_t);

    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'b0, s[16]};
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO; head entry is driven straight from storage.
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH      = 27,
    parameter int unsigned DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_nearly_full,
    output logic             o_overflow
);

    localparam int unsigned DEPTH = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   CNT_ONE = 1;
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  r_overflow;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push;

    assign w_pop  = i_rd_en && (r_count != '0);
    assign w_full = (r_count == (DEPTH_BITS + 1)'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push = i_wr_en && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_overflow <= i_wr_en && w_full && !w_pop;
        end
    end

    assign o_dout        = r_mem[r_rd_ptr];
    assign o_empty       = (r_count == '0);
    assign o_nearly_full = (r_count >= (DEPTH_BITS + 1)'(DEPTH - 1));
    assign o_overflow    = r_overflow;

endmodule

// File: rtl/op_lut_ip_checksum_ttl.sv
// Snoops the input stream, checks the IPv4 header checksum and derives TTL-1 with an
// incrementally updated checksum, queueing one result entry per packet.
module op_lut_ip_checksum_ttl
    import op_lut_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned INFO_FIFO_DEPTH_BITS = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] in_tdata,
    input  logic                           in_tvalid,
    input  logic                           in_tready,
    input  logic                           in_tlast,
    input  logic                           rd_preprocess_info,
    output logic                           ip_checksum_vld,
    output logic                           ip_checksum_is_good,
    output logic                           ip_hdr_has_options,
    output logic                           ip_ttl_is_good,
    output logic [7:0]                     ip_new_ttl,
    output logic [15:0]                    ip_new_checksum,
    output logic                           info_nearly_full,
    output logic                           info_overflow
);

    parse_state_e    r_state;
    parse_state_e    w_state_next;
    logic            w_beat;
    logic            w_launch;
    logic [15:0]     w_sum1;
    logic [7:0]      r_ver_ihl;
    logic [7:0]      r_ttl;
    logic [7:0]      r_proto;
    logic [15:0]     r_cksum;
    logic [15:0]     r_sum1;
    logic            r_short;
    logic [16:0]     r_sum_raw;
    logic            r_s0_vld;
    logic            r_s1_vld;
    info_entry_t     r_s1_entry;
    info_entry_t     w_entry;
    logic [15:0]     w_fold;
    logic [7:0]      w_new_ttl;
    logic [INFO_WIDTH-1:0] w_dout;
    info_entry_t     w_head;
    logic            w_empty;
    logic            w_unused_tdata;

    assign w_beat   = in_tvalid && in_tready;
    assign w_launch = w_beat && (((r_state == StWord1) && in_tlast) || (r_state == StWord2));
    assign w_unused_tdata = ^{in_tdata[239:144], ETH_TYPE_IPV4};

    always_comb begin
        w_sum1 = 16'h0000;
        for (int i = 0; i < IP_HDR1_WORDS; i++) begin
            w_sum1 = ones_add16(w_sum1, in_tdata[IP_HDR1_HI - 16 * i -: 16]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= StWord1;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StWord1:   if (w_beat) w_state_next = in_tlast ? StWord1 : StWord2;
            StWord2:   if (w_beat) w_state_next = in_tlast ? StWord1 : StWaitEop;
            StWaitEop: if (w_beat && in_tlast) w_state_next = StWord1;
            default:   w_state_next = StWord1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_beat && (r_state == StWord1)) begin
            r_ver_ihl <= in_tdata[IP_VER_IHL_HI -: 8];
            r_ttl     <= in_tdata[IP_TTL_HI -: 8];
            r_proto   <= in_tdata[IP_PROTO_HI -: 8];
            r_cksum   <= in_tdata[IP_CKSUM_HI -: 16];
            r_sum1    <= w_sum1;
            r_short   <= in_tlast;
        end
        if (w_beat && (r_state == StWord2)) begin
            r_sum_raw <= {1'b0, r_sum1} + {1'b0, in_tdata[IP_HDR2_HI -: 16]};
        end
        if (r_s0_vld) begin
            r_s1_entry <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0_vld <= 1'b0;
            r_s1_vld <= 1'b0;
        end else begin
            r_s0_vld <= w_launch;
            r_s1_vld <= r_s0_vld;
        end
    end

    // Stage 1: fold the carry of the full-header sum and apply the RFC1624 update.
    always_comb begin
        w_fold    = r_sum_raw[15:0] + {15'b0, r_sum_raw[16]};
        w_new_ttl = (r_ttl == 8'h00) ? 8'h00 : r_ttl - 8'd1;
        w_entry.is_good     = !r_short && (w_fold == 16'hFFFF);
        w_entry.has_options = (r_ver_ihl != IPV4_VER_IHL);
        w_entry.ttl_good    = (r_ttl > 8'd1);
        w_entry.new_ttl     = w_new_ttl;
        w_entry.new_cksum   = ~ones_add16(ones_add16(~r_cksum, ~{r_ttl, r_proto}),
                                          {w_new_ttl, r_proto});
    end

    fallthrough_small_fifo #(
        .WIDTH      (INFO_WIDTH),
        .DEPTH_BITS (INFO_FIFO_DEPTH_BITS)
    ) u_info_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_din         (r_s1_entry),
        .i_wr_en       (r_s1_vld),
        .i_rd_en       (rd_preprocess_info),
        .o_dout        (w_dout),
        .o_empty       (w_empty),
        .o_nearly_full (info_nearly_full),
        .o_overflow    (info_overflow)
    );

    assign ip_checksum_vld     = !w_empty;
    assign w_head              = ip_checksum_vld ? info_entry_t'(w_dout) : '0;
    assign ip_checksum_is_good = w_head.is_good;
    assign ip_hdr_has_options  = w_head.has_options;
    assign ip_ttl_is_good      = w_head.ttl_good;
    assign ip_new_ttl          = w_head.new_ttl;
    assign ip_new_checksum     = w_head.new_cksum;

endmodule

// File: tb/tb_op_lut_ip_checksum_ttl.sv
// Directed bench for op_lut_ip_checksum_ttl: hand-computed IPv4 headers, FIFO boundaries, reset.
module tb_op_lut_ip_checksum_ttl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] in_tdata = '0;
    logic         in_tvalid = 1'b0;
    logic         in_tready = 1'b1;
    logic         in_tlast = 1'b0;
    logic         rd = 1'b0;
    logic         ip_checksum_vld;
    logic         ip_checksum_is_good;
    logic         ip_hdr_has_options;
    logic         ip_ttl_is_good;
    logic [7:0]   ip_new_ttl;
    logic [15:0]  ip_new_checksum;
    logic         info_nearly_full;
    logic         info_overflow;
    logic [26:0]  head;

    int n_tests = 0;
    int n_fail  = 0;

    op_lut_ip_checksum_ttl dut (
        .clk                 (clk),
        .reset               (reset),
        .in_tdata            (in_tdata),
        .in_tvalid           (in_tvalid),
        .in_tready           (in_tready),
        .in_tlast            (in_tlast),
        .rd_preprocess_info  (rd),
        .ip_checksum_vld     (ip_checksum_vld),
        .ip_checksum_is_good (ip_checksum_is_good),
        .ip_hdr_has_options  (ip_hdr_has_options),
        .ip_ttl_is_good      (ip_ttl_is_good),
        .ip_new_ttl          (ip_new_ttl),
        .ip_new_checksum     (ip_new_checksum),
        .info_nearly_full    (info_nearly_full),
        .info_overflow       (info_overflow)
    );

    always #5 clk = ~clk;

    assign head = {ip_checksum_is_good, ip_hdr_has_options, ip_ttl_is_good, ip_new_ttl,
                   ip_new_checksum};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_b1(input logic [7:0] vi, input logic [7:0] ttl,
                                           input logic [15:0] ck);
        logic [255:0] d;
        d = '0;
        d[255:208] = 48'h0200_0000_0001;
        d[159:144] = 16'h0800;
        d[143:136] = vi;
        d[127:112] = 16'h0073;
        d[95:80]   = 16'h4000;
        d[79:72]   = ttl;
        d[71:64]   = 8'h11;
        d[63:48]   = ck;
        d[47:16]   = 32'hC0A8_0001;
        d[15:0]    = 16'hC0A8;
        return d;
    endfunction

    function automatic logic [255:0] mk_b2();
        logic [255:0] d;
        d = '0;
        d[255:240] = 16'h00C7;
        d[127:96]  = 32'hA5A5_A5A5;
        return d;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [255:0] d, input logic last);
        in_tdata  = d;
        in_tlast  = last;
        in_tvalid = 1'b1;
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic pkt2(input logic [7:0] vi, input logic [7:0] ttl, input logic [15:0] ck);
        beat(mk_b1(vi, ttl, ck), 1'b0);
        beat(mk_b2(), 1'b1);
    endtask

    task automatic pop();
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    initial begin
        logic [7:0] ttl_v;
        cyc(2);
        chk("reset_vld", 32'(ip_checksum_vld), 32'h0);
        chk("reset_head", 32'(head), 32'h0);
        chk("reset_nearly_full", 32'(info_nearly_full), 32'h0);
        chk("reset_overflow", 32'(info_overflow), 32'h0);
        reset = 1'b0;
        cyc(1);

        // Valid header, 3 beats
        beat(mk_b1(8'h45, 8'h40, 16'hB861), 1'b0);
        beat(mk_b2(), 1'b0);
        beat(mk_b2(), 1'b1);
        chk("t1_vld_early", 32'(ip_checksum_vld), 32'h0);
        cyc(1);
        chk("t1_vld", 32'(ip_checksum_vld), 32'h1);
        chk("t1_entry", 32'(head), 32'({1'b1, 1'b0, 1'b1, 8'h3F, 16'hB961}));
        pop();
        chk("t1_pop_vld", 32'(ip_checksum_vld), 32'h0);

        // Bad checksum, TTL 1, options, TTL 0
        pkt2(8'h45, 8'h40, 16'hB862);
        pkt2(8'h45, 8'h01, 16'hF761);
        pkt2(8'h46, 8'h40, 16'hB861);
        pkt2(8'h45, 8'h00, 16'hF861);
        cyc(3);
        chk("t2_badck", 32'(head), 32'({1'b0, 1'b0, 1'b1, 8'h3F, 16'hB962}));
        pop();
        chk("t2_ttl1", 32'(head), 32'({1'b1, 1'b0, 1'b0, 8'h00, 16'hF861}));
        pop();
        chk("t2_options", 32'(head), 32'({1'b0, 1'b1, 1'b1, 8'h3F, 16'hB961}));
        pop();
        chk("t2_ttl0", 32'(head), 32'({1'b1, 1'b0, 1'b0, 8'h00, 16'hF861}));
        pop();
        chk("t2_empty", 32'(ip_checksum_vld), 32'h0);

        // Short packet followed directly by a full one
        beat(mk_b1(8'h45, 8'h40, 16'hB861), 1'b1);
        pkt2(8'h45, 8'h40, 16'hB861);
        cyc(3);
        chk("t3_short", 32'(head), 32'({1'b0, 1'b0, 1'b1, 8'h3F, 16'hB961}));
        pop();
        chk("t3_next", 32'(head), 32'({1'b1, 1'b0, 1'b1, 8'h3F, 16'hB961}));
        pop();
        chk("t3_empty", 32'(ip_checksum_vld), 32'h0);

        // Five back-to-back packets into a depth-4 FIFO
        for (int k = 0; k < 5; k++) begin
            ttl_v = 8'((k + 1) * 16);
            pkt2(8'h45, ttl_v, 16'hB861);
            if (k == 2) chk("t4_nf_count2", 32'(info_nearly_full), 32'h0);
            if (k == 3) chk("t4_nf_count3", 32'(info_nearly_full), 32'h1);
        end
        chk("t4_ovf_before", 32'(info_overflow), 32'h0);
        cyc(1);
        chk("t4_ovf_wait", 32'(info_overflow), 32'h0);
        cyc(1);
        chk("t4_ovf_pulse", 32'(info_overflow), 32'h1);
        cyc(1);
        chk("t4_ovf_end", 32'(info_overflow), 32'h0);
        chk("t4_nf_full", 32'(info_nearly_full), 32'h1);
        for (int k = 0; k < 4; k++) begin
            chk("t4_order", 32'(ip_new_ttl), 32'((k + 1) * 16 - 1));
            pop();
        end
        chk("t4_empty", 32'(ip_checksum_vld), 32'h0);

        // Push and pop on the same edge at count 1, then pop when empty
        pkt2(8'h45, 8'h10, 16'hB861);
        cyc(3);
        chk("t5_count1", 32'(ip_checksum_vld), 32'h1);
        beat(mk_b1(8'h45, 8'h20, 16'hB861), 1'b0);
        beat(mk_b2(), 1'b1);
        cyc(1);
        pop();
        chk("t5_vld_after_pushpop", 32'(ip_checksum_vld), 32'h1);
        chk("t5_head_b", 32'(ip_new_ttl), 32'h1F);
        cyc(2);
        pop();
        chk("t5_empty", 32'(ip_checksum_vld), 32'h0);
        pop();
        chk("t5_pop_empty_vld", 32'(ip_checksum_vld), 32'h0);
        chk("t5_pop_empty_head", 32'(head), 32'h0);
        chk("t5_pop_empty_nf", 32'(info_nearly_full), 32'h0);
        pkt2(8'h45, 8'h30, 16'hB861);
        cyc(3);
        chk("t5_after_vld", 32'(ip_checksum_vld), 32'h1);
        chk("t5_after_ttl", 32'(ip_new_ttl), 32'h2F);
        pop();
        chk("t5_after_empty", 32'(ip_checksum_vld), 32'h0);

        // Reset in WAIT_EOP with two entries queued
        pkt2(8'h45, 8'h10, 16'hB861);
        pkt2(8'h45, 8'h20, 16'hB861);
        cyc(3);
        chk("t6_queued", 32'(ip_checksum_vld), 32'h1);
        beat(mk_b1(8'h45, 8'h30, 16'hB861), 1'b0);
        beat(mk_b2(), 1'b0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("t6_vld_reset", 32'(ip_checksum_vld), 32'h0);
        chk("t6_head_reset", 32'(head), 32'h0);
        cyc(4);
        chk("t6_no_stale_push", 32'(ip_checksum_vld), 32'h0);
        beat(mk_b1(8'h45, 8'h77, 16'hB861), 1'b0);
        beat(mk_b2(), 1'b1);
        cyc(3);
        chk("t6_new_vld", 32'(ip_checksum_vld), 32'h1);
        chk("t6_new_ttl", 32'(ip_new_ttl), 32'h76);
        chk("t6_new_ttl_good", 32'(ip_ttl_is_good), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
